// File: rtl/sincos_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sincos_gen : phase-accumulator sin/cos generator, quarter-wave float32 table
// Rev 1.0
// -----------------------------------------------------------------------------
module sincos_gen #(
    parameter int    ADDR_W   = 8,
    parameter string ROM_FILE = "sin_quarter.mif"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sta,
    input  logic        load,
    input  logic [31:0] phase_init,
    input  logic [31:0] phase_inc,
    output logic [31:0] sin_theta,
    output logic [31:0] cos_theta,
    output logic        done_sig
);

    localparam int              c_N       = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_N_IDX   = {1'b1, {ADDR_W{1'b0}}};
    // pi/2 in unsigned Q4.60
    localparam logic [63:0]     c_HALF_PI = 64'h1921FB54442D1846;

    // Elaboration-time float32 (round-to-nearest-even) of sin(k*pi/2/N),
    // from a Q4.60 Taylor series accurate far below float32 resolution.
    function automatic logic [31:0] f_sin_f32(input int k);
        logic [63:0] v_x, v_x2, v_term, v_acc, v_mant, v_rem, v_half;
        logic [31:0] v_res;
        int          v_msb, v_sh, v_exp;
        v_res = 32'd0;
        if (k != 0) begin
            v_x    = 64'((128'(c_HALF_PI) * 128'($unsigned(k))) >> ADDR_W);
            v_x2   = 64'((128'(v_x) * 128'(v_x)) >> 60);
            v_term = v_x;
            v_acc  = v_x;
            for (int j = 1; j <= 12; j++) begin
                v_term = 64'(((128'(v_term) * 128'(v_x2)) >> 60)
                             / 128'($unsigned((2 * j) * (2 * j + 1))));
                if (j % 2 == 1) v_acc = v_acc - v_term;
                else            v_acc = v_acc + v_term;
            end
            v_msb = 0;
            for (int b = 0; b < 64; b++) begin
                if (v_acc[b]) v_msb = b;
            end
            v_sh   = v_msb - 23;
            v_mant = v_acc >> v_sh;
            v_rem  = v_acc & ((64'd1 << v_sh) - 64'd1);
            v_half = 64'd1 << (v_sh - 1);
            if ((v_rem > v_half) || ((v_rem == v_half) && v_mant[0]))
                v_mant = v_mant + 64'd1;
            v_exp = 127 + v_msb - 60;
            if (v_mant[24]) begin
                v_mant = v_mant >> 1;
                v_exp  = v_exp + 1;
            end
            v_res = {1'b0, v_exp[7:0], v_mant[22:0]};
        end
        return v_res;
    endfunction

    logic [31:0] w_rom [0:c_N];

    for (genvar k = 0; k <= c_N; k++) begin : g_rom
        localparam logic [31:0] c_ENTRY = f_sin_f32(k);
        assign w_rom[k] = c_ENTRY;
    end

    // Table contents come from the sine definition itself, so no external
    // file is read; the file name is accepted for drop-in compatibility.
    if (ROM_FILE != "") begin : g_rom_file_name
    end

    logic [31:0]       r_phase;
    logic [31:0]       w_q;
    logic              r_s1_vld;
    logic [1:0]        r_s1_quad;
    logic [ADDR_W-1:0] r_s1_idx;
    logic [ADDR_W:0]   w_idx_a;
    logic [ADDR_W:0]   w_idx_b;
    logic              r_s2_vld;
    logic [1:0]        r_s2_quad;
    logic [31:0]       r_t_a;
    logic [31:0]       r_t_b;
    logic [31:0]       w_sin_mag;
    logic [31:0]       w_cos_mag;
    logic              w_sin_neg;
    logic              w_cos_neg;
    logic [31:0]       w_sin;
    logic [31:0]       w_cos;
    logic [31:0]       r_sin;
    logic [31:0]       r_cos;
    logic              r_done;

    // A load in the request cycle bypasses the accumulator for the lookup.
    assign w_q = load ? phase_init : r_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase   <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_quad <= '0;
            r_s1_idx  <= '0;
        end else begin
            if (load || sta) r_phase <= w_q + (sta ? phase_inc : 32'd0);
            r_s1_vld <= sta;
            if (sta) begin
                r_s1_quad <= w_q[31:30];
                r_s1_idx  <= w_q[29 -: ADDR_W];
            end
        end
    end

    assign w_idx_a = {1'b0, r_s1_idx};
    assign w_idx_b = c_N_IDX - w_idx_a;

    always_ff @(posedge clk) begin
        if (r_s1_vld) begin
            r_t_a <= w_rom[w_idx_a];
            r_t_b <= w_rom[w_idx_b];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_quad <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_quad <= r_s1_quad;
        end
    end

    // Odd quadrants use the mirrored entry; zero magnitude never gets a sign.
    assign w_sin_mag = r_s2_quad[0] ? r_t_b : r_t_a;
    assign w_cos_mag = r_s2_quad[0] ? r_t_a : r_t_b;
    assign w_sin_neg = r_s2_quad[1];
    assign w_cos_neg = r_s2_quad[1] ^ r_s2_quad[0];
    assign w_sin     = (w_sin_mag[30:0] == 31'd0) ? 32'd0
                     : {w_sin_mag[31] ^ w_sin_neg, w_sin_mag[30:0]};
    assign w_cos     = (w_cos_mag[30:0] == 31'd0) ? 32'd0
                     : {w_cos_mag[31] ^ w_cos_neg, w_cos_mag[30:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_sin  <= '0;
            r_cos  <= '0;
        end else begin
            r_done <= r_s2_vld;
            if (r_s2_vld) begin
                r_sin <= w_sin;
                r_cos <= w_cos;
            end
        end
    end

    assign sin_theta = r_sin;
    assign cos_theta = r_cos;
    assign done_sig  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sincos_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sincos_gen : scoreboard bench for sincos_gen
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_sincos_gen;

    localparam int AW = 8;
    localparam int N  = 1 << AW;

    typedef struct {
        logic [31:0] s;
        logic [31:0] c;
        int          cyc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sta;
    logic        load;
    logic [31:0] phase_init;
    logic [31:0] phase_inc;
    logic [31:0] sin_theta;
    logic [31:0] cos_theta;
    logic        done_sig;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n_sta = 0;
    logic [31:0] m_p;
    logic [31:0] tab [0:N];
    ent_t        exp_q[$];
    ent_t        obs_q[$];
    ent_t        mon_e;

    sincos_gen #(
        .ADDR_W  (AW),
        .ROM_FILE("sin_quarter.mif")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sta       (sta),
        .load      (load),
        .phase_init(phase_init),
        .phase_inc (phase_inc),
        .sin_theta (sin_theta),
        .cos_theta (cos_theta),
        .done_sig  (done_sig)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (done_sig === 1'b1) begin
            mon_e.s   = sin_theta;
            mon_e.c   = cos_theta;
            mon_e.cyc = cyc;
            obs_q.push_back(mon_e);
        end
    end

    // float32 round-to-nearest of sin(k*pi/2/N), via double precision
    function automatic logic [31:0] f_tab(input int k);
        real         r;
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] mr;
        logic [28:0] rem;
        int          e;
        if (k == 0) return 32'd0;
        r   = $sin(real'(k) * (3.14159265358979323846 / 2.0) / real'(N));
        d   = $realtobits(r);
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {1'b1, d[51:0]};
        mr  = {1'b0, m[52:29]};
        rem = m[28:0];
        if ((rem > 29'h10000000) || ((rem == 29'h10000000) && mr[0])) mr = mr + 25'd1;
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        return {1'b0, e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] f_neg(input logic [31:0] x);
        return (x == 32'd0) ? 32'd0 : (x ^ 32'h80000000);
    endfunction

    function automatic logic [63:0] f_model(input logic [31:0] q);
        logic [31:0] a, b, s, c;
        int          i;
        i = int'(q[29 -: AW]);
        a = tab[i];
        b = tab[N - i];
        case (q[31:30])
            2'd0:    begin s = a;        c = b;        end
            2'd1:    begin s = b;        c = f_neg(a); end
            2'd2:    begin s = f_neg(a); c = f_neg(b); end
            default: begin s = f_neg(b); c = a;        end
        endcase
        return {s, c};
    endfunction

    // One cycle of stimulus with an explicitly supplied expected sample.
    task automatic drive_exp(input logic s, input logic l, input logic [31:0] pi,
                             input logic [31:0] inc, input logic [31:0] xs,
                             input logic [31:0] xc);
        ent_t e;
        sta        = s;
        load       = l;
        phase_init = pi;
        phase_inc  = inc;
        if (s) begin
            e.s   = xs;
            e.c   = xc;
            e.cyc = cyc + 3;
            exp_q.push_back(e);
            n_sta++;
        end
        if (l && s)  m_p = pi + inc;
        else if (l)  m_p = pi;
        else if (s)  m_p = m_p + inc;
        @(posedge clk);
        #1;
        sta  = 1'b0;
        load = 1'b0;
    endtask

    task automatic drive(input logic s, input logic l, input logic [31:0] pi,
                         input logic [31:0] inc);
        logic [63:0] sc;
        sc = f_model(l ? pi : m_p);
        drive_exp(s, l, pi, inc, sc[63:32], sc[31:0]);
    endtask

    task automatic test_reset;
        rst = 1'b0; sta = 1'b0; load = 1'b0; phase_init = '0; phase_inc = '0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (done_sig !== 1'b0 || sin_theta !== 32'd0 || cos_theta !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: done=%b sin=%h cos=%h, expected 0/0/0", done_sig, sin_theta, cos_theta);
        end
        rst = 1'b1;
        m_p = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            total++;
            if (done_sig !== 1'b0 || sin_theta !== 32'd0 || cos_theta !== 32'd0) begin
                bad++;
                $display("FAIL idle_after_reset: done=%b sin=%h cos=%h, expected 0/0/0", done_sig, sin_theta, cos_theta);
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL idle_strobes: got %0d strobes, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_basic;
        ent_t e, o;
        drive_exp(1'b1, 1'b1, 32'h00000000, 32'h0, 32'h00000000, 32'h3F800000);
        repeat (4) drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive_exp(1'b1, 1'b1, 32'h20000000, 32'h0, 32'h3F3504F3, 32'h3F3504F3);
        repeat (4) drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive_exp(1'b1, 1'b1, 32'h40000000, 32'h0, 32'h3F800000, 32'h00000000);
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL basic_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.s !== e.s || o.c !== e.c || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL basic_sample: got sin=%h cos=%h cyc=%0d, expected sin=%h cos=%h cyc=%0d", o.s, o.c, o.cyc, e.s, e.c, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        ent_t e, o;
        drive_exp(1'b1, 1'b1, 32'hC0000000, 32'h40000000, 32'hBF800000, 32'h00000000);
        drive_exp(1'b1, 1'b0, 32'h0,        32'h40000000, 32'h00000000, 32'h3F800000);
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.s !== e.s || o.c !== e.c || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL b2b_sample: got sin=%h cos=%h cyc=%0d, expected sin=%h cos=%h cyc=%0d", o.s, o.c, o.cyc, e.s, e.c, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++;
            if (done_sig !== 1'b0 || sin_theta !== 32'h00000000 || cos_theta !== 32'h3F800000) begin
                bad++;
                $display("FAIL hold_outputs: done=%b sin=%h cos=%h, expected 0/00000000/3f800000", done_sig, sin_theta, cos_theta);
            end
        end
    endtask

    task automatic test_load_inflight;
        ent_t e, o;
        drive(1'b1, 1'b0, 32'h0,        32'h01000000);
        drive(1'b0, 1'b1, 32'h12345678, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 32'h0,        32'h55555555);
        drive(1'b1, 1'b0, 32'h0,        32'h00100000);
        drive(1'b1, 1'b0, 32'h0,        32'h0);
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL load_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.s !== e.s || o.c !== e.c || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL load_sample: got sin=%h cos=%h cyc=%0d, expected sin=%h cos=%h cyc=%0d", o.s, o.c, o.cyc, e.s, e.c, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midflight;
        ent_t e, o;
        drive(1'b1, 1'b1, 32'h20000000, 32'h10000000);
        drive(1'b1, 1'b0, 32'h0,        32'h10000000);
        rst = 1'b0;
        exp_q.delete();
        m_p = '0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++;
            if (done_sig !== 1'b0 || sin_theta !== 32'd0 || cos_theta !== 32'd0) begin
                bad++;
                $display("FAIL midreset_state: done=%b sin=%h cos=%h, expected 0/0/0", done_sig, sin_theta, cos_theta);
            end
        end
        rst = 1'b1;
        drive_exp(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h00000000, 32'h3F800000);
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL midreset_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.s !== e.s || o.c !== e.c || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL midreset_sample: got sin=%h cos=%h cyc=%0d, expected sin=%h cos=%h cyc=%0d", o.s, o.c, o.cyc, e.s, e.c, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random;
        ent_t        e, o;
        logic        s, l;
        logic [31:0] inc_r, pi;
        int          n0, n_req;
        n0    = n_sta;
        inc_r = $urandom;
        while (n_sta < n0 + 10000) begin
            s  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 7) == 0);
            pi = $urandom;
            if ($urandom_range(0, 3) == 0) pi = {pi[31:30], 30'd0};
            if ($urandom_range(0, 3) == 0) inc_r = $urandom;
            drive(s, l, pi, inc_r);
        end
        n_req = n_sta - n0;
        repeat (6) begin @(posedge clk); #1; end
        total++;
        if (obs_q.size() != n_req) begin
            bad++;
            $display("FAIL random_count: got %0d strobes, expected %0d", obs_q.size(), n_req);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o.s !== e.s || o.c !== e.c || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL random_sample: got sin=%h cos=%h cyc=%0d, expected sin=%h cos=%h cyc=%0d", o.s, o.c, o.cyc, e.s, e.c, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        for (int k = 0; k <= N; k++) tab[k] = f_tab(k);
        test_reset();
        test_basic();
        test_back_to_back();
        test_load_inflight();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
